// File: rtl/digit_serial_add_sub.sv
// Digit-serial add/subtract unit. It handles D bits per cycle over N-bit operands in unsigned, ones' or two's format.
// Optional feature macro: DIGIT_SERIAL_ADD_SUB_SATURATE_EN (clamp result on overflow).
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// CALC  | first digit pass, A + B' + cin, LSB digit first
// EAC   | ones' mode only: second pass adds the end-around carry
// DONE  | result and flags valid, held until out_ready
module digit_serial_add_sub #(
  parameter int N = 16,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  input  logic         sub,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         carry,
  output logic         overflow
);
  localparam int ND = N / D;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [CW-1:0] LAST = CW'(ND - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_EAC, S_DONE} state_t;
  state_t state_q, state_d;

  logic [N-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cy_q, cy_d, raw_c_q, raw_c_d;
  logic          uns_q, uns_d, ones_q, ones_d, sub_q, sub_d;
  logic          a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic          carry_q, carry_d, ovf_q, ovf_d;

  logic [D-1:0]  add_x, add_y;
  logic [D:0]    sum;
  logic [N-1:0]  b_eff;
  logic          last, finishing, raw_fin;

  assign last  = (cnt_q == LAST);
  assign b_eff = sub ? ~op_b : op_b;

  // The EAC pass reuses the digit adder on the result register with a zero addend.
  always_comb begin
    add_x = a_q[D-1:0];
    add_y = b_q[D-1:0];
    if (state_q == S_EAC) begin
      add_x = res_q[D-1:0];
      add_y = '0;
    end
    sum = {1'b0, add_x} + {1'b0, add_y} + {{D{1'b0}}, cy_q};
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid)  state_d = S_CALC;
      S_CALC: if (last)      state_d = ones_q ? S_EAC : S_DONE;
      S_EAC:  if (last)      state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE) && !rst;
    out_valid = (state_q == S_DONE);
    result    = res_q;
    carry     = carry_q;
    overflow  = ovf_q;
  end

  // Datapath next-state. Operands rotate so digit k always sits at bit 0.
  // Result digits shift in from the top and are LSB-aligned after ND steps.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    raw_c_d = raw_c_q;
    uns_d   = uns_q;
    ones_d  = ones_q;
    sub_d   = sub_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    finishing = 1'b0;
    raw_fin   = raw_c_q;

    case (state_q)
      S_IDLE: if (in_valid) begin
        a_d     = op_a;
        b_d     = b_eff;
        uns_d   = (mode == 2'b00);
        ones_d  = (mode == 2'b01);
        sub_d   = sub;
        a_msb_d = op_a[N-1];
        b_msb_d = b_eff[N-1];
        cnt_d   = '0;
        cy_d    = sub & (mode != 2'b01);
      end
      S_CALC: begin
        a_d   = (a_q >> D) | (a_q << (N - D));
        b_d   = (b_q >> D) | (b_q << (N - D));
        res_d = (res_q >> D) | (N'(sum[D-1:0]) << (N - D));
        cy_d  = sum[D];
        cnt_d = last ? '0 : cnt_q + CW'(1);
        if (last) begin
          raw_c_d   = sum[D];
          raw_fin   = sum[D];
          finishing = !ones_q;
        end
      end
      S_EAC: begin
        res_d     = (res_q >> D) | (N'(sum[D-1:0]) << (N - D));
        cy_d      = sum[D];
        cnt_d     = last ? '0 : cnt_q + CW'(1);
        finishing = last;
      end
      default: ;
    endcase

    if (finishing) begin
      carry_d = (uns_q & sub_q) ? ~raw_fin : raw_fin;
      ovf_d   = uns_q ? carry_d
                      : ((a_msb_q == b_msb_q) && (res_d[N-1] != a_msb_q));
`ifdef DIGIT_SERIAL_ADD_SUB_SATURATE_EN
      if (ovf_d) begin
        if (uns_q) res_d = sub_q ? '0 : '1;
        else       res_d = a_msb_q ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      raw_c_q <= 1'b0;
      uns_q   <= 1'b0;
      ones_q  <= 1'b0;
      sub_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      raw_c_q <= raw_c_d;
      uns_q   <= uns_d;
      ones_q  <= ones_d;
      sub_q   <= sub_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
